vec_check_harness: RTL and testbench

Parametrised self-checking vector harness for two-operand arithmetic cores. It steps through DEPTH stored vectors (operand A, operand B, expected Z) from external single-port ROMs and launches the attached core with an ap_ctrl_hs start/ready/done handshake. Each core result is compared with the expected value, and the harness reports the mismatch count, the first failing index and, optionally, a watchdog timeout. It sits at top level in place of the fixed 22-vector, single-core wrapper and adds width/depth generality, stop-on-fail and timeout behaviour.

---
 rtl/vch_pkg.sv | 33 +++
 rtl/vec_check_harness_if.sv | 38 +++
 rtl/vch_watchdog.sv | 40 ++++
 rtl/vec_check_harness.sv | 196 +++++++++++++++++++
 tb/tb_vec_check_harness.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : vch_pkg                                                       |
// | Description: Shared types, default parameters and helpers for the         |
// |              vec_check_harness codebase slice.                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package vch_pkg;

  // Default configuration constants
  localparam int c_DATA_W  = 64;
  localparam int c_DEPTH   = 22;
  localparam int c_ADDR_W  = 5;
  localparam int c_CNT_W   = 5;
  localparam int c_TIMEOUT = 1023;

  // One-hot harness sequencer states
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_FETCH  = 6'b000010,
    S_LAUNCH = 6'b000100,
    S_WAIT   = 6'b001000,
    S_CHECK  = 6'b010000,
    S_DONE   = 6'b100000
  } vch_state_e;

  // Increment that sticks at max_val instead of wrapping
  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
    return (val >= max_val) ? val : val + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_check_harness_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : vec_check_harness_if                                         |
// | Description: Vector ROM port and arithmetic-core ap_ctrl_hs bus between   |
// |              the harness (master) and ROM/core side (slave).              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface vec_check_harness_if
  import vch_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W
);

  logic [ADDR_W-1:0] vec_addr;
  logic              vec_ce;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] z_q;
  logic              dut_start;
  logic              dut_ready;
  logic              dut_done;
  logic [DATA_W-1:0] dut_a;
  logic [DATA_W-1:0] dut_b;
  logic [DATA_W-1:0] dut_result;

  modport master (
    output vec_addr, vec_ce, dut_start, dut_a, dut_b,
    input  a_q, b_q, z_q, dut_ready, dut_done, dut_result
  );

  modport slave (
    input  vec_addr, vec_ce, dut_start, dut_a, dut_b,
    output a_q, b_q, z_q, dut_ready, dut_done, dut_result
  );

endinterface
`default_nettype wire

// File: rtl/vch_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : vch_watchdog                                                  |
// | Description: Down-counter bounding how long the harness waits on the core.|
// |              Loaded on the way into LAUNCH; expires on the TIMEOUT-th     |
// |              enabled cycle. Used only when VCH_TIMEOUT_EN is defined.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module vch_watchdog
  import vch_pkg::*;
#(
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int c_CW = $clog2(TIMEOUT + 1);

  logic [c_CW-1:0] r_cnt;

  // Reload on entry to a launch, count down while waiting on the core
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_CW'(TIMEOUT);
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_CW'(1);
    end
  end

  // A value of one left means this enabled cycle is the last one allowed
  assign expired = en && (r_cnt <= c_CW'(1));

endmodule
`default_nettype wire

// File: rtl/vec_check_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : vec_check_harness                                            |
// | Description: Steps DEPTH ROM vectors through an ap_ctrl_hs arithmetic     |
// |              core, compares results with expected values and reports the  |
// |              mismatch count and first failing index.                      |
// |              Optional watchdog: define VCH_TIMEOUT_EN.                    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module vec_check_harness
  import vch_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int DEPTH   = c_DEPTH,
  parameter int ADDR_W  = c_ADDR_W,
  parameter int CNT_W   = c_CNT_W,
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic              stop_on_fail,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic [CNT_W-1:0]  ap_return,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_vld,
  output logic              timeout_flag,
  vec_check_harness_if.master bus
);

  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam int unsigned       c_CNT_MAX  = (2 ** CNT_W) - 1;

  vch_state_e        r_state;
  vch_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_ffi;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ffv;
  logic              r_tof;
  logic              r_sof;
  logic              r_entry;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_exp;
  logic [DATA_W-1:0] r_res;
  logic              w_clr;
  logic              w_cap;
  logic              w_tmo;
  logic              w_mis;
  logic              w_fail;
  logic              w_expired;

  assign w_mis  = (r_res != r_exp);
  assign w_fail = ((r_state == S_CHECK) && w_mis) || w_tmo;

`ifdef VCH_TIMEOUT_EN
  logic w_wd_load;
  logic w_wd_en;

  assign w_wd_load = (r_state == S_FETCH);
  assign w_wd_en   = (r_state == S_LAUNCH) || (r_state == S_WAIT);

  vch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .load    (w_wd_load),
    .en      (w_wd_en),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Sequencer state register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle strobes; a result arriving wins over expiry
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cap       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        if (bus.dut_ready && bus.dut_done) begin
          w_cap       = 1'b1;
          w_state_nxt = S_CHECK;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (bus.dut_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.dut_done) begin
          w_cap       = 1'b1;
          w_state_nxt = S_CHECK;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_CHECK: begin
        if ((r_idx == c_LAST_IDX) || (r_sof && w_mis)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping, operand staging and result capture
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_idx   <= '0;
      r_ffi   <= '0;
      r_cnt   <= '0;
      r_ffv   <= 1'b0;
      r_tof   <= 1'b0;
      r_sof   <= 1'b0;
      r_entry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_exp   <= '0;
      r_res   <= '0;
    end else begin
      // ROM data is valid only in the first LAUNCH cycle, right after FETCH
      r_entry <= (r_state == S_FETCH);
      if (w_clr) begin
        r_idx <= '0;
        r_cnt <= '0;
        r_ffv <= 1'b0;
        r_tof <= 1'b0;
        r_sof <= stop_on_fail;
      end
      if (r_entry) begin
        r_a   <= bus.a_q;
        r_b   <= bus.b_q;
        r_exp <= bus.z_q;
      end
      if (w_cap) begin
        r_res <= bus.dut_result;
      end
      if (w_fail) begin
        r_cnt <= CNT_W'(sat_inc(32'(r_cnt), c_CNT_MAX));
        if (!r_ffv) begin
          r_ffi <= r_idx;
          r_ffv <= 1'b1;
        end
      end
      if (w_tmo) begin
        r_tof <= 1'b1;
      end
      if ((r_state == S_CHECK) && (w_state_nxt == S_FETCH)) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
    end
  end

  assign ap_done        = (r_state == S_DONE);
  assign ap_ready       = ap_done;
  assign ap_idle        = (r_state == S_IDLE) && !ap_start;
  assign ap_return      = r_cnt;
  assign first_fail_idx = r_ffi;
  assign first_fail_vld = r_ffv;
  assign timeout_flag   = r_tof;
  assign bus.vec_addr   = r_idx;
  assign bus.vec_ce     = (r_state == S_FETCH);
  assign bus.dut_start  = (r_state == S_LAUNCH);
  assign bus.dut_a      = r_a;
  assign bus.dut_b      = r_b;

endmodule
`default_nettype wire

// File: tb/tb_vec_check_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_vec_check_harness                                         |
// | Description: Directed bench for vec_check_harness with ROM and core       |
// |              models; expected run results go through a scoreboard queue.  |
// |              Timeout scenario selected by VCH_TIMEOUT_EN.                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vec_check_harness;

  localparam int c_N = 22;

  typedef struct {
    int     ret;
    bit     ffv;
    int     ffi;
    bit     tof;
    longint done_cyc;
    int     hs;
    int     maxrun;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst, ap_start, stop_on_fail;
  logic ap_done, ap_ready, ap_idle, first_fail_vld, timeout_flag;
  logic [4:0] ap_return, first_fail_idx;

  vec_check_harness_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  vec_check_harness #(
    .DATA_W(64), .DEPTH(c_N), .ADDR_W(5), .CNT_W(5), .TIMEOUT(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .stop_on_fail(stop_on_fail),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_return(ap_return),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
    .timeout_flag(timeout_flag), .bus(bus)
  );

  always #5 ap_clk = ~ap_clk;

  logic [63:0] A [c_N];
  logic [63:0] B [c_N];
  logic [63:0] ZT [c_N];
  logic [c_N-1:0] corrupt;
  int  rdelay, lat, hang_idx;
  bit  dwr, hang_en;
  int  n_chk = 0, n_err = 0;
  longint cyc = 0;
  exp_t q[$];
  int  hs, maxrun, runlen;
  bit  prev_done, saw_done;
  int  rom_idx, pend, rdy_cnt, lat_cnt;
  bit  busy, in_launch, chk_ops;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int ret, bit ffv, int ffi, bit tof, int hsn, int mr);
    exp_t e;
    e.ret = ret; e.ffv = ffv; e.ffi = ffi; e.tof = tof;
    e.done_cyc = 0; e.hs = hsn; e.maxrun = mr;
    return e;
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;

  // ROM model: one-cycle read latency, corrupted expected values where flagged
  always @(posedge ap_clk) begin
    if (bus.vec_ce) begin
      bus.a_q <= A[bus.vec_addr];
      bus.b_q <= B[bus.vec_addr];
      bus.z_q <= ZT[bus.vec_addr] ^ {63'd0, corrupt[bus.vec_addr]};
      rom_idx <= int'(bus.vec_addr);
    end
  end

  // Core model: ready after rdelay cycles of start, done lat cycles later (or with ready)
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      bus.dut_ready = 1'b0; bus.dut_done = 1'b0;
      busy = 0; in_launch = 0; chk_ops = 0;
    end else begin
      bus.dut_ready = 1'b0;
      bus.dut_done  = 1'b0;
      if (chk_ops) begin
        chk("dut_a", longint'(bus.dut_a), longint'(A[pend]));
        chk("dut_b", longint'(bus.dut_b), longint'(B[pend]));
        chk_ops = 0;
      end
      if (busy) begin
        if (lat_cnt > 0) lat_cnt--;
        if (lat_cnt == 0 && !(hang_en && pend == hang_idx)) begin
          bus.dut_done = 1'b1; bus.dut_result = ZT[pend]; busy = 0;
        end
      end
      if (bus.dut_start) begin
        if (!in_launch) begin in_launch = 1; rdy_cnt = 0; end
        if (rdy_cnt == rdelay) begin
          bus.dut_ready = 1'b1; pend = rom_idx; chk_ops = 1; hs++;
          if (dwr) begin
            bus.dut_done = 1'b1; bus.dut_result = ZT[pend];
          end else begin
            busy = 1; lat_cnt = lat;
          end
        end
        rdy_cnt++;
      end else begin
        in_launch = 0;
      end
    end
  end

  // Monitor: pops the expected run record whenever the harness signals done
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      hs = 0; maxrun = 0; runlen = 0; prev_done = 0;
    end else begin
      if (bus.dut_start) begin
        runlen++;
        if (runlen > maxrun) maxrun = runlen;
      end else begin
        runlen = 0;
      end
      if (prev_done) chk("done_pulse_width", ap_done, 0);
      if (ap_done) begin
        saw_done = 1;
        chk("ap_ready_eq_done", ap_ready, 1);
        chk("run_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ap_return", ap_return, e.ret);
          chk("first_fail_vld", first_fail_vld, e.ffv);
          if (e.ffv) chk("first_fail_idx", first_fail_idx, e.ffi);
          chk("timeout_flag", timeout_flag, e.tof);
          chk("done_cycle", cyc, e.done_cyc);
          chk("handshakes", hs, e.hs);
          chk("start_run_len", maxrun, e.maxrun);
        end
        hs = 0; maxrun = 0;
      end
      prev_done = ap_done;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!ap_idle && k < 100) begin @(negedge ap_clk); k++; end
    chk("idle_before_start", ap_idle, 1);
  endtask

  task automatic run(input bit sof, input exp_t e, input int latency, input bit poke);
    int k;
    wait_idle();
    ap_start = 1'b1; stop_on_fail = sof;
    e.done_cyc = cyc + latency;
    q.push_back(e);
    @(negedge ap_clk);
    ap_start = 1'b0; stop_on_fail = 1'b0;
    if (poke) begin
      repeat (50) @(negedge ap_clk);
      ap_start = 1'b1; stop_on_fail = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0; stop_on_fail = 1'b0;
    end
    k = 0;
    while (q.size() != 0 && k < 3000) begin @(negedge ap_clk); k++; end
    if (q.size() != 0) begin
      chk("run_completed", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    for (int i = 0; i < c_N; i++) begin
      A[i]  = 64'hA5A5_0000_0000_0000 ^ (64'(i) * 64'h0001_0203_0405_0607);
      B[i]  = {32'(i * 7 + 1), 32'hDEAD_BEEF};
      ZT[i] = A[i] + B[i];
    end
    corrupt = '0; rdelay = 0; lat = 5; dwr = 0; hang_en = 0; hang_idx = 0;
    bus.dut_ready = 1'b0; bus.dut_done = 1'b0; bus.dut_result = '0;
    bus.a_q = '0; bus.b_q = '0; bus.z_q = '0;
    saw_done = 0;
    ap_rst = 1'b1; ap_start = 1'b0; stop_on_fail = 1'b0;
    repeat (3) @(negedge ap_clk);

    // Reset state
    chk("rst_ap_done", ap_done, 0);
    chk("rst_ap_ready", ap_ready, 0);
    chk("rst_dut_start", bus.dut_start, 0);
    chk("rst_vec_ce", bus.vec_ce, 0);
    chk("rst_ffv", first_fail_vld, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_ap_return", ap_return, 0);
    chk("rst_ffi", first_fail_idx, 0);
    chk("rst_vec_addr", bus.vec_addr, 0);
    chk("rst_dut_a", longint'(bus.dut_a), 0);
    chk("rst_dut_b", longint'(bus.dut_b), 0);
    chk("rst_ap_idle", ap_idle, 1);
    ap_start = 1'b1; #1;
    chk("rst_ap_idle_with_start", ap_idle, 0);
    ap_start = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // Clean pass: 22 x 8 + 1 cycles
    run(0, mk(0, 0, 0, 0, 22, 1), 177, 0);
    // Vectors 3 and 17 corrupted, full run, with a stray mid-run start
    corrupt[3] = 1'b1; corrupt[17] = 1'b1;
    run(0, mk(2, 1, 3, 0, 22, 1), 177, 1);
    // Stop on first fail: 4 vectors x 8 + 1
    run(1, mk(1, 1, 3, 0, 4, 1), 33, 0);
    // Ready delayed 3, done with ready: 22 x 6 + 1
    corrupt = '0; rdelay = 3; dwr = 1;
    run(0, mk(0, 0, 0, 0, 22, 4), 133, 0);
    // Ready delayed 1, latency 2, corrupted: 22 x 6 + 1
    corrupt[3] = 1'b1; corrupt[17] = 1'b1; rdelay = 1; dwr = 0; lat = 2;
    run(0, mk(2, 1, 3, 0, 22, 2), 133, 0);

    // Core never completes vector 0
    corrupt = '0; rdelay = 0; lat = 5; hang_en = 1; hang_idx = 0;
`ifdef VCH_TIMEOUT_EN
    run(0, mk(1, 1, 0, 1, 1, 1), 18, 0);
`else
    wait_idle();
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    saw_done = 0;
    repeat (1000) @(negedge ap_clk);
    chk("no_done_without_watchdog", saw_done, 0);
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
`endif
    hang_en = 0;

    // Reset while waiting on vector 10
    corrupt[3] = 1'b1; corrupt[17] = 1'b1;
    wait_idle();
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    k = 0;
    while (!(bus.dut_start && bus.vec_addr == 5'd10) && k < 1000) begin
      @(negedge ap_clk); k++;
    end
    chk("reached_vector_10", bus.dut_start && bus.vec_addr == 5'd10, 1);
    @(negedge ap_clk);
    chk("pre_reset_count", ap_return, 1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("mid_rst_ap_idle", ap_idle, 1);
    chk("mid_rst_ap_return", ap_return, 0);
    chk("mid_rst_dut_start", bus.dut_start, 0);
    chk("mid_rst_vec_ce", bus.vec_ce, 0);
    chk("mid_rst_ffv", first_fail_vld, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    run(0, mk(2, 1, 3, 0, 22, 1), 177, 0);

    repeat (3) @(negedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
